// File: rtl/reg_dst_mux_pkg.sv
// Select codes shared by the control unit and the register-file destination mux.
package reg_dst_mux_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_E0  = 3'd0;
  localparam sel_t SEL_E1  = 3'd1;
  localparam sel_t SEL_E2  = 3'd2;
  localparam sel_t SEL_E3  = 3'd3;
  localparam sel_t SEL_E4  = 3'd4;
  localparam sel_t SEL_MAX = 3'd4;

endpackage

// File: rtl/reg_dst_mux.sv
// Registered 5:1 selector for the register-file write destination/data.
// Optional illegal-code flag sel_err when REG_DST_MUX_SEL_ERR_EN is defined.
module reg_dst_mux
  import reg_dst_mux_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] entry0,
  input  logic [WIDTH-1:0] entry1,
  input  logic [WIDTH-1:0] entry2,
  input  logic [WIDTH-1:0] entry3,
  input  logic [WIDTH-1:0] entry4,
  input  sel_t             controlSingal,
  output logic [WIDTH-1:0] out
`ifdef REG_DST_MUX_SEL_ERR_EN
  ,
  output logic             sel_err
`endif
);

  logic [WIDTH-1:0] mux_d;

  // Codes above SEL_MAX resolve to zero so out is never X.
  always_comb begin
    mux_d = '0;
    case (controlSingal)
      SEL_E0:  mux_d = entry0;
      SEL_E1:  mux_d = entry1;
      SEL_E2:  mux_d = entry2;
      SEL_E3:  mux_d = entry3;
      SEL_E4:  mux_d = entry4;
      default: mux_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out <= RESET_VAL;
    end else begin
      out <= mux_d;
    end
  end

`ifdef REG_DST_MUX_SEL_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= (controlSingal > SEL_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_reg_dst_mux.sv
// Self-checking bench for reg_dst_mux: directed table, corner sequences, random vs. model.
module tb_reg_dst_mux;

  logic        clk;
  logic        reset_n;
  logic [31:0] ent [5];
  logic [2:0]  code;
  logic [31:0] out;
`ifdef REG_DST_MUX_SEL_ERR_EN
  logic        sel_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reg_dst_mux #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .entry0        (ent[0]),
    .entry1        (ent[1]),
    .entry2        (ent[2]),
    .entry3        (ent[3]),
    .entry4        (ent[4]),
    .controlSingal (code),
    .out           (out)
`ifdef REG_DST_MUX_SEL_ERR_EN
    ,
    .sel_err       (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  // Reference: the value selected by the code as seen at the edge, zero for illegal codes or reset.
  function automatic logic [31:0] model_out(input bit rst_n, input int c);
    if (!rst_n) return 32'h0;
    if (c > 4) return 32'h0;
    return ent[c];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name, input logic exp);
`ifdef REG_DST_MUX_SEL_ERR_EN
    check(name, {31'b0, sel_err}, {31'b0, exp});
`else
    if (exp) begin end
    if (name.len() == 0) begin end
`endif
  endtask

  task automatic set_sweep_entries();
    ent[0] = 32'h0000FFFF;
    ent[1] = 32'h000001FF;
    ent[2] = 32'h0000001F;
    ent[3] = 32'h00000001;
    ent[4] = 32'h00000000;
  endtask

  initial begin
    logic [31:0] exp;
    bit          exp_err;

    tbl[0] = '{3'd0, 32'h0000FFFF};
    tbl[1] = '{3'd1, 32'h000001FF};
    tbl[2] = '{3'd2, 32'h0000001F};
    tbl[3] = '{3'd3, 32'h00000001};
    tbl[4] = '{3'd4, 32'h00000000};
    tbl[5] = '{3'd0, 32'h0000FFFF};

    // Reset with an arbitrary code and nonzero data.
    reset_n = 1'b0;
    code    = 3'd3;
    for (int i = 0; i < 5; i++) ent[i] = 32'hDEAD0000 | i;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("reset_out", out, 32'h0);
      check_err("reset_sel_err", 1'b0);
    end

    // Sweep codes 0..4 then back to 0, each held 10 clocks.
    set_sweep_entries();
    reset_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      code = tbl[v].code;
      for (int k = 0; k < 10; k++) begin
        tick();
        check($sformatf("sweep_code%0d_clk%0d", tbl[v].code, k), out, tbl[v].exp);
        check_err("sweep_sel_err", 1'b0);
      end
    end

    // Illegal codes with all-ones data.
    for (int i = 0; i < 5; i++) ent[i] = 32'hFFFFFFFF;
    for (int c = 5; c < 8; c++) begin
      code = c[2:0];
      tick();
      check($sformatf("illegal_code%0d", c), out, 32'h0);
      check_err($sformatf("illegal_sel_err%0d", c), 1'b1);
    end
    code = 3'd1;
    tick();
    check("after_illegal_out", out, 32'hFFFFFFFF);
    check_err("after_illegal_sel_err", 1'b0);

    // Same-edge code and data change: new code must pick new data.
    set_sweep_entries();
    code = 3'd0;
    tick();
    check("samecycle_pre", out, 32'h0000FFFF);
    ent[2] = 32'hA5A5A5A5;
    code   = 3'd2;
    tick();
    check("samecycle_new_data", out, 32'hA5A5A5A5);

    // Mid-run reset for one clock while code=1.
    set_sweep_entries();
    code = 3'd1;
    tick();
    check("midreset_pre", out, 32'h000001FF);
    reset_n = 1'b0;
    tick();
    check("midreset_asserted", out, 32'h0);
    check_err("midreset_sel_err", 1'b0);
    reset_n = 1'b1;
    tick();
    check("midreset_release", out, 32'h000001FF);

    // Random stimulus against the model, including occasional resets.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 5; i++) ent[i] = $urandom;
      code    = 3'($urandom_range(0, 7));
      reset_n = ($urandom_range(0, 15) != 0);
      exp     = model_out(reset_n, int'(code));
      exp_err = reset_n && (code > 3'd4);
      tick();
      check($sformatf("rand%0d_code%0d_rst%0d", n, code, reset_n), out, exp);
      check_err($sformatf("rand%0d_sel_err", n), exp_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
